// File: rtl/stage_responder_pkg.sv
// stage_responder_pkg: shared state type, default width and counter sizing for stage_responder.
package stage_responder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam int DATA_W_DEF = 8;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/stage_responder_if.sv
// stage_responder_if: start/done handshake bundle between a stage sequencer and its responder.
interface stage_responder_if
    import stage_responder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic                  start;
    logic [DATA_W-1:0]     op_a;
    logic [DATA_W-1:0]     op_b;
    logic                  done;
    logic [2*DATA_W-1:0]   result;
    logic                  busy;
    logic                  overrun;

    modport master (output start, op_a, op_b, input done, result, busy, overrun);
    modport slave  (input start, op_a, op_b, output done, result, busy, overrun);
endinterface

// File: rtl/stage_responder_mul.sv
// stage_responder_mul: iterative shift-add multiplier datapath, one multiplier bit per step.
module stage_responder_mul
    import stage_responder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic                step_i,
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    output logic                last_o,
    output logic [2*DATA_W-1:0] acc_o
);
    localparam int CW = cnt_w(DATA_W);

    logic [2*DATA_W-1:0] mcand_q, mcand_d, acc_q, acc_d, sum;
    logic [DATA_W-1:0]   mplr_q, mplr_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    // acc_o already includes the current step so the final add lands in result on the last cycle
    always_comb begin
        sum     = acc_q + (mplr_q[0] ? mcand_q : '0);
        mcand_d = load_i ? {{DATA_W{1'b0}}, a_i} : step_i ? mcand_q << 1 : mcand_q;
        mplr_d  = load_i ? b_i : step_i ? mplr_q >> 1 : mplr_q;
        acc_d   = load_i ? '0 : step_i ? sum : acc_q;
        cnt_d   = load_i ? CW'(DATA_W) : step_i ? cnt_q - CW'(1) : cnt_q;
        last_o  = cnt_q == CW'(1);
        acc_o   = sum;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/stage_responder.sv
// stage_responder: start/done worker computing an unsigned product; FSM, pending slot, output registers.
// Define STAGE_RESPONDER_PEND_EN to add a one-deep pending slot for starts that arrive while busy.
module stage_responder
    import stage_responder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    stage_responder_if.slave   bus
);
    state_e                state_q, state_d;
    logic                  load, step, last, launch, start_busy, pend_next;
    logic                  done_q, busy_q, busy_d, ovr_q, ovr_d;
    logic [DATA_W-1:0]     ld_a, ld_b;
    logic [2*DATA_W-1:0]   acc, result_q, result_d;

`ifdef STAGE_RESPONDER_PEND_EN
    logic              pend_v_q, pend_v_d, accept;
    logic [DATA_W-1:0] pend_a_q, pend_b_q;

    // the slot frees up in the cycle it is launched, so a start then refills it
    assign launch     = state_q == DONE && pend_v_q;
    assign start_busy = bus.start && (state_q == RUN || launch);
    assign accept     = start_busy && (!pend_v_q || launch);
    assign ovr_d      = start_busy && !accept;
    assign pend_v_d   = accept || (pend_v_q && !launch);
    assign pend_next  = pend_v_d;
    assign ld_a       = launch ? pend_a_q : bus.op_a;
    assign ld_b       = launch ? pend_b_q : bus.op_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_v_q <= 1'b0;
            pend_a_q <= '0;
            pend_b_q <= '0;
        end else begin
            pend_v_q <= pend_v_d;
            if (accept) begin
                pend_a_q <= bus.op_a;
                pend_b_q <= bus.op_b;
            end
        end
    end
`else
    assign launch     = 1'b0;
    assign start_busy = bus.start && state_q == RUN;
    assign ovr_d      = start_busy;
    assign pend_next  = 1'b0;
    assign ld_a       = bus.op_a;
    assign ld_b       = bus.op_b;
`endif

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        step     = 1'b0;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                load    = bus.start;
                state_d = bus.start ? RUN : IDLE;
            end
            RUN: begin
                step     = 1'b1;
                result_d = last ? acc : result_q;
                state_d  = last ? DONE : RUN;
            end
            DONE: begin
                load    = launch || bus.start;
                state_d = load ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_d = state_d == RUN || (state_d == DONE && pend_next);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= state_d == DONE;
            busy_q   <= busy_d;
            ovr_q    <= ovr_d;
            result_q <= result_d;
        end
    end

    stage_responder_mul #(.DATA_W(DATA_W)) u_mul (
        .clk    (clk),
        .reset  (reset),
        .load_i (load),
        .step_i (step),
        .a_i    (ld_a),
        .b_i    (ld_b),
        .last_o (last),
        .acc_o  (acc)
    );

    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = ovr_q;
    assign bus.result  = result_q;
endmodule

// File: tb/tb_stage_responder.sv
// tb_stage_responder: directed per-cycle vectors for stage_responder with DATA_W=8.
module tb_stage_responder;
    typedef logic [15:0] quad_t [4];

    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] last_res = 16'd0;

    stage_responder_if #(.DATA_W(8)) bus ();

    stage_responder #(.DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // cycle c of a vector: bit c of each mask; ops/res are consumed in order of starts/dones
    task automatic play(input string tag, input int n, input logic [31:0] st_m,
                        input logic [31:0] done_m, input logic [31:0] busy_m,
                        input logic [31:0] ovr_m, input quad_t ops, input quad_t res);
        int j = 0;
        int k = 0;
        for (int c = 0; c < n; c++) begin
            if (c > 0) begin
                check($sformatf("%s c%0d done/busy/ovr", tag, c),
                      {29'd0, bus.done, bus.busy, bus.overrun},
                      {29'd0, done_m[c], busy_m[c], ovr_m[c]});
                if (done_m[c]) begin
                    check($sformatf("%s c%0d result", tag, c), {16'd0, bus.result}, {16'd0, res[k]});
                    last_res = res[k];
                    k++;
                end else if (c == 1) begin
                    check($sformatf("%s c1 result hold", tag), {16'd0, bus.result}, {16'd0, last_res});
                end
            end
            bus.start = st_m[c];
            {bus.op_a, bus.op_b} = st_m[c] ? ops[j] : 16'h0000;
            if (st_m[c]) j++;
            tick();
        end
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        tick();
        tick();
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset overrun", {31'd0, bus.overrun}, 32'd0);
        check("reset result", {16'd0, bus.result}, 32'd0);
        reset = 1'b0;
        tick();

        play("13x11", 11, 32'h1, 32'h200, 32'h1FE, 32'h0, '{16'h0D0B, 0, 0, 0}, '{16'd143, 0, 0, 0});
        play("255x255", 11, 32'h1, 32'h200, 32'h1FE, 32'h0, '{16'hFFFF, 0, 0, 0}, '{16'd65025, 0, 0, 0});
        play("0x200", 11, 32'h1, 32'h200, 32'h1FE, 32'h0, '{16'h00C8, 0, 0, 0}, '{16'd0, 0, 0, 0});
        play("1x1", 11, 32'h1, 32'h200, 32'h1FE, 32'h0, '{16'h0101, 0, 0, 0}, '{16'd1, 0, 0, 0});
        play("chain", 20, 32'h201, 32'h40200, 32'h3FDFE, 32'h0,
             '{16'h0505, 16'h0607, 0, 0}, '{16'd25, 16'd42, 0, 0});
`ifdef STAGE_RESPONDER_PEND_EN
        play("pend", 20, 32'h29, 32'h40200, 32'h3FFFE, 32'h40,
             '{16'h0305, 16'h0404, 16'h0202, 0}, '{16'd15, 16'd16, 0, 0});
`else
        play("nopend", 20, 32'h29, 32'h200, 32'h1FE, 32'h50,
             '{16'h0305, 16'h0404, 16'h0202, 0}, '{16'd15, 0, 0, 0});
`endif

        bus.start = 1'b1;
        bus.op_a  = 8'd200;
        bus.op_b  = 8'd3;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        check("mid-run busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort done", {31'd0, bus.done}, 32'd0);
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort overrun", {31'd0, bus.overrun}, 32'd0);
        check("abort result", {16'd0, bus.result}, 32'd0);
        tick();
        reset = 1'b0;
        last_res = 16'd0;
        play("post-reset idle", 12, 32'h0, 32'h0, 32'h0, 32'h0, '{0, 0, 0, 0}, '{0, 0, 0, 0});
        play("9x9", 11, 32'h1, 32'h200, 32'h1FE, 32'h0, '{16'h0909, 0, 0, 0}, '{16'd81, 0, 0, 0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
